// File: rtl/wb_initiator.sv
`default_nettype none
// ============================================================================
// Module      : wb_initiator
// Description : Wishbone classic single-cycle master with a watchdog timeout,
//               driven by a valid/ready command stream and returning a held
//               valid/ready response.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_initiator #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_val,
    output logic        cmd_rdy,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_dat,
    output logic        rsp_val,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    localparam logic [1:0]      c_IDLE    = 2'd0;
    localparam logic [1:0]      c_BUS     = 2'd1;
    localparam logic [1:0]      c_RSP     = 2'd2;
    localparam logic [TO_W-1:0] c_WD_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      r_state;
    logic [TO_W-1:0] r_wdog;
    logic            r_cyc;
    logic            r_we;
    logic [3:0]      r_sel;
    logic [31:0]     r_adr;
    logic [31:0]     r_wdat;
    logic            r_rsp_val;
    logic [31:0]     r_rsp_dat;
    logic            r_rsp_err;

    // Only the command-ready flag is decoded; everything else leaves a flop.
    assign cmd_rdy   = (r_state == c_IDLE);
    assign rsp_val   = r_rsp_val;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_wdat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_wdog    <= '0;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= 4'd0;
            r_adr     <= 32'd0;
            r_wdat    <= 32'd0;
            r_rsp_val <= 1'b0;
            r_rsp_dat <= 32'd0;
            r_rsp_err <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (cmd_val) begin
                        r_we    <= cmd_we;
                        r_sel   <= cmd_sel;
                        r_adr   <= cmd_adr;
                        r_wdat  <= cmd_dat;
                        r_cyc   <= 1'b1;
                        r_wdog  <= '0;
                        r_state <= c_BUS;
                    end
                end
                c_BUS: begin
                    // An ack on the watchdog's last cycle still completes normally.
                    if (wbm_ack_i) begin
                        r_rsp_dat <= r_we ? 32'd0 : wbm_dat_i;
                        r_rsp_err <= 1'b0;
                        r_rsp_val <= 1'b1;
                        r_cyc     <= 1'b0;
                        r_state   <= c_RSP;
                    end else if (r_wdog == c_WD_LAST) begin
                        r_rsp_dat <= 32'd0;
                        r_rsp_err <= 1'b1;
                        r_rsp_val <= 1'b1;
                        r_cyc     <= 1'b0;
                        r_state   <= c_RSP;
                    end else begin
                        r_wdog <= r_wdog + TO_W'(1);
                    end
                end
                c_RSP: begin
                    if (rsp_rdy) begin
                        r_rsp_val <= 1'b0;
                        r_state   <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_initiator
// Description : Self-checking bench for wb_initiator: two instances (short and
//               long watchdog) against a transaction-timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_initiator;

    localparam int c_N = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [c_N];
    logic        cmd_val   [c_N];
    logic        cmd_rdy   [c_N];
    logic        cmd_we    [c_N];
    logic [31:0] cmd_adr   [c_N];
    logic [3:0]  cmd_sel   [c_N];
    logic [31:0] cmd_dat   [c_N];
    logic        rsp_val   [c_N];
    logic        rsp_rdy   [c_N];
    logic [31:0] rsp_dat   [c_N];
    logic        rsp_err   [c_N];
    logic        wbm_cyc   [c_N];
    logic        wbm_stb   [c_N];
    logic        wbm_we    [c_N];
    logic [3:0]  wbm_sel   [c_N];
    logic [31:0] wbm_adr   [c_N];
    logic [31:0] wbm_dat_o [c_N];
    logic [31:0] wbm_dat_i [c_N];
    logic        wbm_ack   [c_N];
    logic        s_ack     [c_N];
    logic        spur      [c_N];

    generate
        for (genvar g = 0; g < c_N; g++) begin : g_dut
            assign wbm_ack[g] = s_ack[g] | spur[g];
            wb_initiator #(
                .TIMEOUT (g == 0 ? 4 : 16),
                .TO_W    (8)
            ) u_dut (
                .clk       (clk),
                .rst       (rst[g]),
                .cmd_val   (cmd_val[g]),
                .cmd_rdy   (cmd_rdy[g]),
                .cmd_we    (cmd_we[g]),
                .cmd_adr   (cmd_adr[g]),
                .cmd_sel   (cmd_sel[g]),
                .cmd_dat   (cmd_dat[g]),
                .rsp_val   (rsp_val[g]),
                .rsp_rdy   (rsp_rdy[g]),
                .rsp_dat   (rsp_dat[g]),
                .rsp_err   (rsp_err[g]),
                .wbm_cyc_o (wbm_cyc[g]),
                .wbm_stb_o (wbm_stb[g]),
                .wbm_we_o  (wbm_we[g]),
                .wbm_sel_o (wbm_sel[g]),
                .wbm_adr_o (wbm_adr[g]),
                .wbm_dat_o (wbm_dat_o[g]),
                .wbm_ack_i (wbm_ack[g]),
                .wbm_dat_i (wbm_dat_i[g])
            );
        end
    endgenerate

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Slave plan: stb-high cycle index (0-based) on which ack is given, -1 = never.
    int s_wait  [c_N];
    int s_run   [c_N];
    int stb_len [c_N];
    logic [31:0] s_mem [logic [32:0]];

    // Model: each transaction is a timeline (accept phase, bus length, response).
    bit          m_live     [c_N];
    bit          m_rst      [c_N];
    bit          m_busy     [c_N];
    int          m_t0       [c_N];
    int          m_len      [c_N];
    logic        m_we       [c_N];
    logic [3:0]  m_sel      [c_N];
    logic [31:0] m_adr      [c_N];
    logic [31:0] m_dat      [c_N];
    logic [31:0] m_pdat     [c_N];
    logic        m_perr     [c_N];
    logic [31:0] m_last_dat [c_N];
    logic        m_last_err [c_N];
    logic [31:0] m_mem [logic [32:0]];

    function automatic int to_of(input int d);
        return (d == 0) ? 4 : 16;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s[%0d]: got %h, expected %h at %0t", name, d, act, exp, $time);
    endtask

    always @(posedge clk) begin
        logic [32:0] key;
        bit          acked;
        cyc = cyc + 1;
        for (int d = 0; d < c_N; d++) begin
            if (rst[d]) begin
                m_live[d]     = 1'b1;
                m_rst[d]      = 1'b1;
                m_busy[d]     = 1'b0;
                m_last_dat[d] = 32'd0;
                m_last_err[d] = 1'b0;
            end else begin
                m_rst[d] = 1'b0;
                if (!m_busy[d]) begin
                    if (cmd_val[d] && m_live[d]) begin
                        key       = {d[0], cmd_adr[d]};
                        acked     = (s_wait[d] >= 0) && (s_wait[d] < to_of(d));
                        m_busy[d] = 1'b1;
                        m_t0[d]   = cyc;
                        m_len[d]  = acked ? s_wait[d] + 1 : to_of(d);
                        m_we[d]   = cmd_we[d];
                        m_sel[d]  = cmd_sel[d];
                        m_adr[d]  = cmd_adr[d];
                        m_dat[d]  = cmd_dat[d];
                        m_perr[d] = !acked;
                        if (!acked) begin
                            m_pdat[d] = 32'd0;
                        end else if (cmd_we[d]) begin
                            m_mem[key] = merge(m_mem.exists(key) ? m_mem[key] : ~cmd_adr[d],
                                               cmd_dat[d], cmd_sel[d]);
                            m_pdat[d]  = 32'd0;
                        end else begin
                            m_pdat[d] = m_mem.exists(key) ? m_mem[key] : ~cmd_adr[d];
                        end
                    end
                end else if (rsp_rdy[d] && (cyc - 1 >= m_t0[d] + m_len[d])) begin
                    m_busy[d]     = 1'b0;
                    m_last_dat[d] = m_pdat[d];
                    m_last_err[d] = m_perr[d];
                end
            end
        end
    end

    // Compare against the model, then play the slave for the coming cycle.
    task automatic monitor();
        logic [32:0] key;
        bit          e_bus;
        bit          e_rv;
        forever begin
            @(negedge clk);
            for (int d = 0; d < c_N; d++) begin
                if (m_live[d]) begin
                    e_bus = m_busy[d] && (cyc < m_t0[d] + m_len[d]);
                    e_rv  = m_busy[d] && !e_bus;
                    chk("cmd_rdy", d, 32'(cmd_rdy[d]), 32'(!m_busy[d]));
                    chk("wbm_cyc", d, 32'(wbm_cyc[d]), 32'(e_bus));
                    chk("wbm_stb", d, 32'(wbm_stb[d]), 32'(e_bus));
                    chk("rsp_val", d, 32'(rsp_val[d]), 32'(e_rv));
                    chk("rsp_dat", d, rsp_dat[d], e_rv ? m_pdat[d] : m_last_dat[d]);
                    chk("rsp_err", d, 32'(rsp_err[d]), 32'(e_rv ? m_perr[d] : m_last_err[d]));
                    if (e_bus || m_rst[d]) begin
                        chk("wbm_we",  d, 32'(wbm_we[d]),  m_rst[d] ? 32'd0 : 32'(m_we[d]));
                        chk("wbm_sel", d, 32'(wbm_sel[d]), m_rst[d] ? 32'd0 : 32'(m_sel[d]));
                        chk("wbm_adr", d, wbm_adr[d],      m_rst[d] ? 32'd0 : m_adr[d]);
                        chk("wbm_dat", d, wbm_dat_o[d],    m_rst[d] ? 32'd0 : m_dat[d]);
                    end
                end
                if (wbm_cyc[d] && wbm_stb[d]) begin
                    key      = {d[0], wbm_adr[d]};
                    s_run[d] = s_run[d] + 1;
                    if (s_run[d] - 1 == s_wait[d]) begin
                        s_ack[d] = 1'b1;
                        if (wbm_we[d]) begin
                            s_mem[key]   = merge(s_mem.exists(key) ? s_mem[key] : ~wbm_adr[d],
                                                 wbm_dat_o[d], wbm_sel[d]);
                            wbm_dat_i[d] = 32'd0;
                        end else begin
                            wbm_dat_i[d] = s_mem.exists(key) ? s_mem[key] : ~wbm_adr[d];
                        end
                    end else begin
                        s_ack[d]     = 1'b0;
                        wbm_dat_i[d] = 32'hA5A5_A5A5;
                    end
                end else begin
                    if (s_run[d] != 0) stb_len[d] = s_run[d];
                    s_run[d]     = 0;
                    s_ack[d]     = 1'b0;
                    wbm_dat_i[d] = 32'hA5A5_A5A5;
                end
            end
        end
    endtask

    task automatic issue(input int d, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input int wt, output int t_hs);
        @(posedge clk); #2;
        s_wait[d]  = wt;
        cmd_we[d]  = we;
        cmd_adr[d] = adr;
        cmd_sel[d] = sel;
        cmd_dat[d] = dat;
        cmd_val[d] = 1'b1;
        t_hs = -1;
        for (int n = 0; n < 50 && t_hs < 0; n++) begin
            @(negedge clk); #1;
            if (cmd_rdy[d]) t_hs = cyc;
        end
        chk("cmd_accepted", d, 32'(t_hs >= 0), 32'd1);
        @(posedge clk); #2;
        cmd_val[d] = 1'b0;
    endtask

    task automatic wait_rsp(input int d, output int ph);
        ph = -1;
        for (int n = 0; n < 60 && ph < 0; n++) begin
            if (rsp_val[d]) ph = cyc;
            else begin
                @(negedge clk); #1;
            end
        end
        chk("rsp_seen", d, 32'(ph >= 0), 32'd1);
    endtask

    task automatic xact(input int d, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input int wt,
                        output logic [31:0] r_dat, output logic r_err, output int lat, output int stbn);
        int t_hs;
        int ph;
        issue(d, we, adr, sel, dat, wt, t_hs);
        wait_rsp(d, ph);
        r_dat = rsp_dat[d];
        r_err = rsp_err[d];
        lat   = ph - t_hs;
        stbn  = stb_len[d];
        rsp_rdy[d] = 1'b1;
        @(posedge clk); #2;
        rsp_rdy[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        re;
        int          lat;
        int          stbn;
        int          t_hs;
        int          ph;
        int          nv;
        for (int d = 0; d < c_N; d++) begin
            rst[d] = 1'b1;       cmd_val[d] = 1'b0; cmd_we[d]  = 1'b0;
            cmd_adr[d] = 32'd0;  cmd_sel[d] = 4'd0; cmd_dat[d] = 32'd0;
            rsp_rdy[d] = 1'b0;   spur[d] = 1'b0;    s_wait[d]  = 0;
            s_ack[d] = 1'b0;     wbm_dat_i[d] = 32'd0;
            s_run[d] = 0;        stb_len[d] = 0;
        end
        fork
            monitor();
        join_none

        @(posedge clk); #2;
        chk("reset_cmd_rdy", 0, 32'(cmd_rdy[0]), 32'd1);
        chk("reset_rsp_val", 0, 32'(rsp_val[0]), 32'd0);
        chk("reset_wbm_cyc", 1, 32'(wbm_cyc[1]), 32'd0);
        @(posedge clk); #2;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Write then read, zero-wait slave, plus sel = 0 and partial-lane writes.
        xact(0, 1'b1, 32'h3000_0004, 4'hF, 32'hDEAD_BEEF, 0, rd, re, lat, stbn);
        chk("wr_dat", 0, rd, 32'd0);
        chk("wr_err", 0, 32'(re), 32'd0);
        chk("wr_lat", 0, 32'(lat), 32'd2);
        chk("wr_stb_len", 0, 32'(stbn), 32'd1);
        xact(0, 1'b0, 32'h3000_0004, 4'hF, 32'h0, 0, rd, re, lat, stbn);
        chk("rd_dat", 0, rd, 32'hDEAD_BEEF);
        chk("rd_err", 0, 32'(re), 32'd0);
        chk("rd_lat", 0, 32'(lat), 32'd2);
        chk("rd_stb_len", 0, 32'(stbn), 32'd1);
        xact(0, 1'b1, 32'h3000_0004, 4'h0, 32'hFFFF_FFFF, 0, rd, re, lat, stbn);
        xact(0, 1'b1, 32'h3000_0004, 4'h3, 32'h0000_CAFE, 0, rd, re, lat, stbn);
        xact(0, 1'b0, 32'h3000_0004, 4'hF, 32'h0, 0, rd, re, lat, stbn);
        chk("rd_lanes", 0, rd, 32'hDEAD_CAFE);

        // Wait states on the long-watchdog instance.
        xact(1, 1'b1, 32'h0000_1000, 4'hF, 32'h1234_5678, 0, rd, re, lat, stbn);
        xact(1, 1'b0, 32'h0000_1000, 4'hF, 32'h0, 4, rd, re, lat, stbn);
        chk("ws_dat", 1, rd, 32'h1234_5678);
        chk("ws_err", 1, 32'(re), 32'd0);
        chk("ws_stb_len", 1, 32'(stbn), 32'd5);
        chk("ws_lat", 1, 32'(lat), 32'd6);

        // Watchdog with TIMEOUT = 4: no ack, then ack on the last allowed cycle.
        xact(0, 1'b0, 32'h3000_0004, 4'hF, 32'h0, -1, rd, re, lat, stbn);
        chk("to_err", 0, 32'(re), 32'd1);
        chk("to_dat", 0, rd, 32'd0);
        chk("to_stb_len", 0, 32'(stbn), 32'd4);
        chk("to_lat", 0, 32'(lat), 32'd5);
        xact(0, 1'b0, 32'h3000_0004, 4'hF, 32'h0, 3, rd, re, lat, stbn);
        chk("to_edge_err", 0, 32'(re), 32'd0);
        chk("to_edge_dat", 0, rd, 32'hDEAD_CAFE);
        chk("to_edge_stb_len", 0, 32'(stbn), 32'd4);

        // Backpressure: response held 10 cycles while a new command waits.
        issue(0, 1'b0, 32'h3000_0004, 4'hF, 32'h0, 0, t_hs);
        wait_rsp(0, ph);
        @(posedge clk); #2;
        s_wait[0]  = 0;
        cmd_we[0]  = 1'b1;
        cmd_sel[0] = 4'hF;
        cmd_dat[0] = 32'h0BAD_F00D;
        cmd_val[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cmd_adr[0] = 32'h4000_0000 + i;
            @(negedge clk); #1;
            chk("bp_cmd_rdy", 0, 32'(cmd_rdy[0]), 32'd0);
            chk("bp_rsp_val", 0, 32'(rsp_val[0]), 32'd1);
            chk("bp_rsp_dat", 0, rsp_dat[0], 32'hDEAD_CAFE);
        end
        cmd_adr[0] = 32'h3000_0008;
        rsp_rdy[0] = 1'b1;
        @(posedge clk); #2;
        rsp_rdy[0] = 1'b0;
        @(negedge clk); #1;
        chk("bp_rdy_after", 0, 32'(cmd_rdy[0]), 32'd1);
        chk("bp_stb_not_yet", 0, 32'(wbm_stb[0]), 32'd0);
        @(posedge clk); #2;
        cmd_val[0] = 1'b0;
        @(negedge clk); #1;
        chk("bp_stb_next", 0, 32'(wbm_stb[0]), 32'd1);
        chk("bp_adr", 0, wbm_adr[0], 32'h3000_0008);
        wait_rsp(0, ph);
        rsp_rdy[0] = 1'b1;
        @(posedge clk); #2;
        rsp_rdy[0] = 1'b0;

        // Reset on the second bus cycle of a never-acked read.
        issue(0, 1'b0, 32'h3000_0004, 4'hF, 32'h0, -1, t_hs);
        @(posedge clk); #2;
        rst[0] = 1'b1;
        @(posedge clk); #2;
        rst[0] = 1'b0;
        chk("rst_cyc", 0, 32'(wbm_cyc[0]), 32'd0);
        chk("rst_stb", 0, 32'(wbm_stb[0]), 32'd0);
        chk("rst_rsp_val", 0, 32'(rsp_val[0]), 32'd0);
        chk("rst_cmd_rdy", 0, 32'(cmd_rdy[0]), 32'd1);
        chk("rst_rsp_dat", 0, rsp_dat[0], 32'd0);
        chk("rst_adr", 0, wbm_adr[0], 32'd0);
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (rsp_val[0]) nv = nv + 1;
        end
        chk("rst_no_rsp", 0, 32'(nv), 32'd0);

        // Spurious acks in IDLE and in RSP.
        xact(0, 1'b0, 32'h3000_0008, 4'hF, 32'h0, 0, rd, re, lat, stbn);
        chk("sp_setup_dat", 0, rd, 32'h0BAD_F00D);
        spur[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("sp_idle_rdy", 0, 32'(cmd_rdy[0]), 32'd1);
            chk("sp_idle_rsp_val", 0, 32'(rsp_val[0]), 32'd0);
            chk("sp_idle_rsp_dat", 0, rsp_dat[0], 32'h0BAD_F00D);
        end
        spur[0] = 1'b0;
        issue(0, 1'b0, 32'h3000_0004, 4'hF, 32'h0, 0, t_hs);
        wait_rsp(0, ph);
        spur[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("sp_rsp_val", 0, 32'(rsp_val[0]), 32'd1);
            chk("sp_rsp_dat", 0, rsp_dat[0], 32'hDEAD_CAFE);
        end
        spur[0] = 1'b0;
        rsp_rdy[0] = 1'b1;
        @(posedge clk); #2;
        rsp_rdy[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
